// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit holding HI/LO. The result is computed at
// accept time and held back until the busy countdown expires, which models latency.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HILOsel,
    output logic        busy,
    output logic [31:0] MDout,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } md_res_t;

    md_op_e             op;
    logic               accept;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_init;
    md_res_t            pend;
    md_res_t            res_next;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, den_s, den_u;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

    assign op     = md_op_e'(MDOp);
    assign busy   = (cnt != '0);
    assign accept = start && !busy && (op != MD_NONE) && (op != MD_RSVD);
    assign MDout  = HILOsel ? HI : LO;

    // Signed product via sign-extended 64-bit unsigned multiply (low 64 bits are exact).
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
    assign a_mag = A[31] ? -A : A;
    assign b_mag = B[31] ? -B : B;
    assign den_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag = a_mag / den_s;
    assign r_mag = a_mag % den_s;
    assign q_s   = (A[31] ^ B[31]) ? -q_mag : q_mag;
    assign r_s   = A[31] ? -r_mag : r_mag;

    assign den_u = (B == 32'd0) ? 32'd1 : B;
    assign q_u   = A / den_u;
    assign r_u   = A % den_u;

    always_comb begin
        res_next = '{hi: HI, lo: LO, dz: 1'b0};
        cnt_init = '0;
        unique case (op)
            MD_MULT: begin
                res_next.hi = prod_s[63:32];
                res_next.lo = prod_s[31:0];
                cnt_init    = CNT_W'(MULT_CYCLES);
            end
            MD_MULTU: begin
                res_next.hi = prod_u[63:32];
                res_next.lo = prod_u[31:0];
                cnt_init    = CNT_W'(MULT_CYCLES);
            end
            MD_DIV: begin
                res_next.hi = r_s;
                res_next.lo = q_s;
                res_next.dz = (B == 32'd0);
                cnt_init    = CNT_W'(DIV_CYCLES);
            end
            MD_DIVU: begin
                res_next.hi = r_u;
                res_next.lo = q_u;
                res_next.dz = (B == 32'd0);
                cnt_init    = CNT_W'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI   <= 32'd0;
            LO   <= 32'd0;
            cnt  <= '0;
            pend <= '0;
        end else if (accept) begin
            case (op)
                MD_MTHI: HI <= A;
                MD_MTLO: LO <= A;
                default: begin
                    pend <= res_next;
                    cnt  <= cnt_init;
                end
            endcase
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            // Divide-by-zero still burns the full busy period but leaves HI/LO alone.
            if (cnt == CNT_W'(1) && !pend.dz) begin
                HI <= pend.hi;
                LO <= pend.lo;
            end
        end
    end

endmodule
